// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - mode codes and default width for the alu32 execute unit
package alu32_pkg;

   localparam int WIDTH = 32;

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;

endpackage

// File: rtl/alu32_shifter.sv
// rtl/alu32_shifter.sv - combinational barrel shifter (dir=0 left, dir=1 right; arith sign-fills right shifts)
module alu32_shifter #(
   parameter int WIDTH = 32,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [SW-1:0]    shamt,
   input  logic             dir,
   input  logic             arith,
   output logic [WIDTH-1:0] result
);

   logic fill;

   always_comb begin
      fill   = arith & data[WIDTH-1];
      result = data;
      for (int s = 0; s < SW; s++) begin
         if (shamt[s]) begin
            if (!dir) begin
               result = result << (1 << s);
            end else begin
               result = (result >> (1 << s)) | ({WIDTH{fill}} << (WIDTH - (1 << s)));
            end
         end
      end
   end

endmodule

// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit registered ALU; define ALU32_FLAGS_EN to add zero/carry/ovf flag outputs
module alu32 #(
   parameter int WIDTH = alu32_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       mode,
   output logic [WIDTH-1:0] X
`ifdef ALU32_FLAGS_EN
   ,
   output logic             zero,
   output logic             carry,
   output logic             ovf
`endif
);

   import alu32_pkg::*;

   localparam int SW = $clog2(WIDTH);

   logic             sub;
   logic [WIDTH-1:0] bop;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] shift_res;
   logic [WIDTH-1:0] next_x;
   logic             slt;
   logic             sltu;

   // SUB reuses the adder as A + ~B + 1
   assign sub = (mode == ALU_SUB);
   assign bop = sub ? ~B : B;

`ifdef ALU32_FLAGS_EN
   logic cout;
   logic next_carry;
   logic next_ovf;
   assign {cout, sum} = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
`else
   assign sum = A + bop + {{(WIDTH-1){1'b0}}, sub};
`endif

   assign slt  = ($signed(A) < $signed(B));
   assign sltu = (A < B);

   alu32_shifter #(
      .WIDTH (WIDTH),
      .SW    (SW)
   ) u_shifter (
      .data   (A),
      .shamt  (B[SW-1:0]),
      .dir    (mode != ALU_SLL),
      .arith  (mode == ALU_SRA),
      .result (shift_res)
   );

   always_comb begin
      next_x = '0;
      case (mode)
         ALU_ADD,
         ALU_SUB:  next_x = sum;
         ALU_AND:  next_x = A & B;
         ALU_OR:   next_x = A | B;
         ALU_XOR:  next_x = A ^ B;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  next_x = shift_res;
         ALU_SLT:  next_x = {{(WIDTH-1){1'b0}}, slt};
         ALU_SLTU: next_x = {{(WIDTH-1){1'b0}}, sltu};
         default:  next_x = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         X <= '0;
      end else begin
         X <= next_x;
      end
   end

`ifdef ALU32_FLAGS_EN
   // bop is already inverted for SUB, so one overflow rule covers both
   always_comb begin
      next_carry = 1'b0;
      next_ovf   = 1'b0;
      if (mode == ALU_ADD || mode == ALU_SUB) begin
         next_carry = cout;
         next_ovf   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero  <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         zero  <= (next_x == '0);
         carry <= next_carry;
         ovf   <= next_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - directed vector bench for alu32 (flag checks when ALU32_FLAGS_EN is defined)
module tb_alu32;

   import alu32_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  mode;
      logic [31:0] x;
      logic        z;
      logic        c;
      logic        v;
   } vec_t;

   localparam int NVEC = 25;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  mode;
   logic [31:0] X;
`ifdef ALU32_FLAGS_EN
   logic        zero;
   logic        carry;
   logic        ovf;
`endif

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   alu32 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .mode  (mode),
      .X     (X)
`ifdef ALU32_FLAGS_EN
      ,
      .zero  (zero),
      .carry (carry),
      .ovf   (ovf)
`endif
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      //            a              b              mode      x              z     c     v
      vecs[0]  = '{32'h00000001, 32'h00000002, ALU_ADD,  32'h00000003, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h0000000A, 32'h00000020, ALU_SUB,  32'hFFFFFFEA, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h0000000A, 32'h00000020, ALU_AND,  32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'h0000000A, 32'h00000020, ALU_OR,   32'h0000002A, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h0000000A, 32'h00000020, ALU_XOR,  32'h0000002A, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'h0000000A, 32'h00000020, ALU_SLL,  32'h0000000A, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0000000A, 32'h00000020, ALU_SRL,  32'h0000000A, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h80000001, 32'h00000004, ALU_SLL,  32'h00000010, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'h80000001, 32'h00000004, ALU_SRL,  32'h08000000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'h80000001, 32'h00000004, ALU_SRA,  32'hF8000000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'hFFFFFFFF, 32'h00000001, ALU_SLT,  32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'hFFFFFFFF, 32'h00000001, ALU_SLTU, 32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{32'hFFFFFFFF, 32'h00000001, 4'd12,    32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{32'h7FFFFFFF, 32'h00000001, ALU_ADD,  32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{32'h00000005, 32'h00000005, ALU_SUB,  32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{32'hFFFFFFFF, 32'h00000001, ALU_ADD,  32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{32'h00000000, 32'h00000001, ALU_SUB,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{32'h80000000, 32'h00000001, ALU_SUB,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
      vecs[18] = '{32'h00000001, 32'h00000021, ALU_SLL,  32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{32'h40000000, 32'h00000003, ALU_SRA,  32'h08000000, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{32'h00000001, 32'hFFFFFFFF, ALU_SLTU, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{32'h00000001, 32'hFFFFFFFF, ALU_SLT,  32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[22] = '{32'h00001234, 32'h00005678, ALU_NOP,  32'h00000000, 1'b1, 1'b0, 1'b0};
      vecs[23] = '{32'h80000001, 32'h0000001F, ALU_SRA,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[24] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15,    32'h00000000, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      A     = 32'hFFFFFFFF;
      B     = 32'h00000001;
      mode  = ALU_ADD;

      // reset held two cycles while an overflowing add is presented
      repeat (2) begin
         @(posedge clk);
         #1;
         check32("reset_x", X, 32'h00000000);
`ifdef ALU32_FLAGS_EN
         check1("reset_zero", zero, 1'b0);
         check1("reset_carry", carry, 1'b0);
         check1("reset_ovf", ovf, 1'b0);
`endif
      end

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check32("wrap_add", X, 32'h00000000);
`ifdef ALU32_FLAGS_EN
      check1("wrap_add_zero", zero, 1'b1);
      check1("wrap_add_carry", carry, 1'b1);
`endif

      // new operation every cycle; each result must appear after exactly one edge
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         A    = vecs[i].a;
         B    = vecs[i].b;
         mode = vecs[i].mode;
         @(posedge clk);
         #1;
         check32($sformatf("vec%0d_x", i), X, vecs[i].x);
`ifdef ALU32_FLAGS_EN
         check1($sformatf("vec%0d_zero", i), zero, vecs[i].z);
         check1($sformatf("vec%0d_carry", i), carry, vecs[i].c);
         check1($sformatf("vec%0d_ovf", i), ovf, vecs[i].v);
`endif
      end

      // inputs change but the edge has not come yet: X must still hold the last result
      @(negedge clk);
      A    = 32'h00000001;
      B    = 32'h00000002;
      mode = ALU_ADD;
      #1;
      check32("hold_before_edge", X, 32'h00000000);

      // reset mid-stream discards the pending add
      @(posedge clk);
      #1;
      check32("add_before_reset", X, 32'h00000003);
      @(negedge clk);
      A     = 32'h0000000A;
      B     = 32'h00000005;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check32("mid_reset_x", X, 32'h00000000);
      @(negedge clk);
      rst_n = 1'b1;
      mode  = ALU_SUB;
      @(posedge clk);
      #1;
      check32("after_mid_reset_sub", X, 32'h00000005);
`ifdef ALU32_FLAGS_EN
      check1("after_mid_reset_carry", carry, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
